// File: rtl/spi_master_xfer_seq_if.sv
// spi_master_xfer_seq_if
//   Bundles the system-side valid/ready byte streams and the SPI master
//   strobe bus of the transfer sequencer.
//   slave  : sequencer view (drives s_ready, m_*, SPI strobes, busy)
//   master : environment view (drives s_data/s_valid, m_ready, dout_master)
interface spi_master_xfer_seq_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] din_master;
   logic       ld_master;
   logic       start;
   logic       rd_master;
   logic [7:0] dout_master;
   logic       busy;

   modport slave (
      input  s_data, s_valid, m_ready, dout_master,
      output s_ready, m_data, m_valid, din_master, ld_master, start, rd_master, busy
   );

   modport master (
      output s_data, s_valid, m_ready, dout_master,
      input  s_ready, m_data, m_valid, din_master, ld_master, start, rd_master, busy
   );
endinterface

// File: rtl/spi_master_xfer_seq.sv
// spi_master_xfer_seq
//   Byte-stream sequencer in front of an SPI master. Outgoing bytes queue in a
//   TX FIFO; one transfer at a time is loaded (ld_master), started (start),
//   waited out for XFER_CYCLES cycles, read back (rd_master) and the received
//   byte is pushed into an RX FIFO exposed as a valid/ready stream.
// Ports
//   mclk, rst   : clock, asynchronous active-high reset
//   bus (slave) : s_data/s_valid/s_ready  TX byte stream in
//                 m_data/m_valid/m_ready  RX byte stream out
//                 din_master/ld_master/start/rd_master/dout_master  SPI master
//                 busy  sequencer not idle
//   xfer_count  : completed transfers, saturating (only with SPI_SEQ_XFER_CNT_EN)
// Macro SPI_SEQ_XFER_CNT_EN enables the xfer_count port and counter.
module spi_master_xfer_seq #(
   parameter int DEPTH       = 4,
   parameter int XFER_CYCLES = 16
) (
   input  logic                 mclk,
   input  logic                 rst,
   spi_master_xfer_seq_if.slave bus
`ifdef SPI_SEQ_XFER_CNT_EN
   , output logic [15:0]        xfer_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(XFER_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, CAPT} state_t;

   state_t state, state_nxt;
   logic [CW-1:0] cnt;

   // ---------------- TX FIFO ----------------
   logic [7:0]  tx_mem [DEPTH];
   logic [AW:0] tx_wp, tx_rp;
   logic        tx_empty, tx_full, tx_push, tx_pop;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_push  = bus.s_valid && !tx_full;
   assign tx_pop   = (state == LOAD);

   always_ff @(posedge mclk)
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.s_data;

   always_ff @(posedge mclk or posedge rst)
      if (rst) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end

   // ---------------- RX FIFO ----------------
   logic [7:0]  rx_mem [DEPTH];
   logic [AW:0] rx_wp, rx_rp;
   logic        rx_empty, rx_full, rx_push, rx_pop;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   // CAPT never sees a full RX: IDLE only leaves with a free slot and pops
   // during the transfer only add space.
   assign rx_push  = (state == CAPT);
   assign rx_pop   = !rx_empty && bus.m_ready;

   always_ff @(posedge mclk)
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= bus.dout_master;

   always_ff @(posedge mclk or posedge rst)
      if (rst) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end

   assign bus.s_ready = !tx_full;
   assign bus.m_valid = !rx_empty;
   // Gate the head so an empty (possibly never-written) RAM reads as zero.
   assign bus.m_data  = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];

   // ---------------- FSM ----------------
   always_ff @(posedge mclk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == START)                 cnt <= CW'(XFER_CYCLES - 1);
         else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!tx_empty && !rx_full) state_nxt = LOAD;
         LOAD:  state_nxt = START;
         START: state_nxt = WAIT;
         WAIT:  if (cnt == '0) state_nxt = READ;
         READ:  state_nxt = CAPT;
         CAPT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // din_master shows the TX head during LOAD and holds it afterwards.
   logic [7:0] din_q;
   always_ff @(posedge mclk or posedge rst)
      if (rst)               din_q <= 8'h00;
      else if (state == LOAD) din_q <= tx_mem[tx_rp[AW-1:0]];

   always_comb begin
      bus.ld_master  = 1'b0;
      bus.start      = 1'b0;
      bus.rd_master  = 1'b0;
      bus.busy       = (state != IDLE);
      bus.din_master = din_q;
      case (state)
         LOAD: begin
            bus.ld_master  = 1'b1;
            bus.din_master = tx_mem[tx_rp[AW-1:0]];
         end
         START: bus.start     = 1'b1;
         READ:  bus.rd_master = 1'b1;
         default: ;
      endcase
   end

`ifdef SPI_SEQ_XFER_CNT_EN
   logic [15:0] xfer_cnt;
   always_ff @(posedge mclk or posedge rst)
      if (rst)                                   xfer_cnt <= '0;
      else if (state == CAPT && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
   assign xfer_count = xfer_cnt;
`endif

endmodule

// File: tb/tb_spi_master_xfer_seq.sv
module tb_spi_master_xfer_seq;
   localparam int DEPTH = 4;
   localparam int X     = 16;
   localparam int PER   = 5 + X;

   logic mclk = 1'b0;
   logic rst  = 1'b0;
   always #5 mclk = ~mclk;

   spi_master_xfer_seq_if bus ();
`ifdef SPI_SEQ_XFER_CNT_EN
   logic [15:0] xfer_count;
`endif

   spi_master_xfer_seq #(.DEPTH(DEPTH), .XFER_CYCLES(X)) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
`ifdef SPI_SEQ_XFER_CNT_EN
      , .xfer_count (xfer_count)
`endif
   );

   // SPI master model: answers each loaded byte with byte ^ 8'h99
   logic [7:0] spi_byte = 8'h00;
   always @(posedge mclk) if (bus.ld_master) spi_byte <= bus.din_master;
   assign bus.dout_master = spi_byte ^ 8'h99;

   // cycle index: cycle c begins at posedge number c
   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   int n_ld = 0, n_st = 0, n_rd = 0;
   int ld_cyc = 0, rd_cyc = 0;
   logic [7:0] ld_din = 8'h00;
   int st_q[$];
   logic [7:0] rx_q[$];

   always @(posedge mclk) begin
      if (bus.ld_master) begin n_ld <= n_ld + 1; ld_cyc <= cyc; ld_din <= bus.din_master; end
      if (bus.start)     begin n_st <= n_st + 1; st_q.push_back(cyc); end
      if (bus.rd_master) begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
      if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
   end

   int n_chk = 0, n_pass = 0;
   int last_push = 0, stall = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // called and returns at a negedge
   task automatic push(input logic [7:0] b);
      int t = 0;
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      while (!bus.s_ready && t < 200) begin @(negedge mclk); t++; end
      if (t > 0) stall++;
      if (!bus.s_ready) chk("push_timeout", 0, 1);
      last_push = cyc + 1;
      @(negedge mclk);
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge mclk);
   endtask

   logic [7:0] exp_b  [4] = '{8'h98, 8'h9B, 8'h9A, 8'h9D};
   logic [7:0] exp_bp [6] = '{8'h89, 8'h88, 8'h8B, 8'h8A, 8'h8D, 8'h8C};

   initial begin
      int b0, b1, b2, t, mv;
      bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
      #1 rst = 1'b1;
      wait_cyc(2);
      // reset state
      chk("rst_s_ready",  bus.s_ready, 1);
      chk("rst_m_valid",  bus.m_valid, 0);
      chk("rst_m_data",   bus.m_data, 8'h00);
      chk("rst_din",      bus.din_master, 8'h00);
      chk("rst_strobes",  {bus.ld_master, bus.start, bus.rd_master}, 0);
      chk("rst_busy",     bus.busy, 0);
      rst = 1'b0;

      // idle 50 cycles
      b0 = n_ld + n_st + n_rd;
      wait_cyc(50);
      chk("idle_strobes", n_ld + n_st + n_rd - b0, 0);
      chk("idle_busy",    bus.busy, 0);
      chk("idle_s_ready", bus.s_ready, 1);

      // single byte
      st_q.delete(); rx_q.delete();
      push(8'hA5);
      t = 0;
      while (!bus.m_valid && t < 100) begin @(negedge mclk); t++; end
      chk("single_mv_seen", bus.m_valid, 1);
      mv = cyc;
      chk("single_ld_lat",  ld_cyc, last_push + 1);
      chk("single_ld_din",  ld_din, 8'hA5);
      chk("single_st_lat",  st_q[0], last_push + 2);
      chk("single_wait_len", rd_cyc - st_q[0] - 1, X);
      chk("single_mv_lat",  mv, ld_cyc + 4 + X);
      chk("single_m_data",  bus.m_data, 8'h3C);
      bus.m_ready = 1'b1;
      wait_cyc(2);
      chk("single_popped",  rx_q[0], 8'h3C);
      chk("single_drained", bus.m_valid, 0);

      // burst of four
      st_q.delete(); rx_q.delete(); stall = 0;
      for (int i = 1; i <= 4; i++) push(8'(i));
      wait_cyc(4 * PER + 20);
      chk("burst_no_stall", stall, 0);
      chk("burst_starts",   st_q.size(), 4);
      for (int i = 0; i < 3; i++) chk($sformatf("burst_space%0d", i), st_q[i+1] - st_q[i], PER);
      chk("burst_rx_cnt",   rx_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("burst_rx%0d", i), rx_q[i], exp_b[i]);

      // RX back-pressure
      st_q.delete(); rx_q.delete();
      bus.m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
      wait_cyc(4 * PER + 30);
      chk("bp_starts",   st_q.size(), 4);
      chk("bp_busy",     bus.busy, 0);
      chk("bp_s_ready",  bus.s_ready, 1);
      chk("bp_m_valid",  bus.m_valid, 1);
      chk("bp_m_head",   bus.m_data, 8'h89);
      bus.m_ready = 1'b1;
      wait_cyc(2 * PER + 30);
      chk("bp_starts_all", st_q.size(), 6);
      chk("bp_rx_cnt",     rx_q.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("bp_rx%0d", i), rx_q[i], exp_bp[i]);

      // reset three cycles into WAIT
      push(8'h77);
      t = 0;
      while (!bus.start && t < 50) begin @(negedge mclk); t++; end
      chk("mid_start_seen", bus.start, 1);
      wait_cyc(3);
      #1 rst = 1'b1;
      #1;
      chk("mid_strobes", {bus.ld_master, bus.start, bus.rd_master}, 0);
      chk("mid_busy",    bus.busy, 0);
      chk("mid_din",     bus.din_master, 8'h00);
      @(negedge mclk);
      rst = 1'b0;
      b1 = n_rd;
      wait_cyc(3 * PER);
      chk("mid_no_rd",    n_rd - b1, 0);
      chk("mid_m_valid",  bus.m_valid, 0);
      chk("mid_busy_after", bus.busy, 0);

`ifdef SPI_SEQ_XFER_CNT_EN
      chk("cnt_reset", xfer_count, 16'h0000);
      for (int i = 0; i < 3; i++) push(8'h40 + 8'(i));
      wait_cyc(3 * PER + 20);
      chk("cnt_three", xfer_count, 16'h0003);
      force dut.xfer_cnt = 16'hFFFE;
      @(negedge mclk);
      release dut.xfer_cnt;
      for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
      wait_cyc(3 * PER + 20);
      chk("cnt_sat", xfer_count, 16'hFFFF);
`endif
      b2 = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk + b2);
      $finish;
   end
endmodule

// File: doc/spi_master_xfer_seq.md
Name: spi_master_xfer_seq

Overview:
- Byte-stream sequencer that sits directly upstream and downstream of the SPI master port.
- Buffers outgoing bytes in a TX FIFO, then drives din_master/ld_master/start for one transfer at a time.
- Waits out the fixed transfer time, reads dout_master with rd_master and pushes the received byte into an RX FIFO.
- Gives the system a valid/ready byte interface in place of raw SPI master strobes.

Parameters:
- DEPTH, 4, entries per FIFO (TX and RX); power of two, >= 2.
- XFER_CYCLES, 16, mclk cycles between start pulse and result availability; >= 1.

Ports:
- mclk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  TX byte from system.
- s_valid  in  1  s_data valid.
- s_ready  out  1  TX FIFO not full.
- m_data  out  8  received byte, RX FIFO head.
- m_valid  out  1  RX FIFO not empty.
- m_ready  in  1  consumer accepts m_data.
- din_master  out  8  byte presented to SPI master.
- ld_master  out  1  one-cycle load strobe to SPI master.
- start  out  1  one-cycle transfer start strobe.
- rd_master  out  1  one-cycle read strobe to SPI master.
- dout_master  in  8  SPI master received byte.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, rst=1): FIFOs empty, FSM=IDLE, wait counter=0. Outputs while reset held:
  - s_ready=1, m_valid=0, m_data=0, din_master=0, ld_master=0, start=0, rd_master=0, busy=0.
- TX push on rising mclk when s_valid&&s_ready.
- RX pop on rising mclk when m_valid&&m_ready.
- Both FIFOs allow simultaneous push and pop in one cycle; occupancy is unchanged.
- Pointers are log2(DEPTH)+1 bits; wrap-around is correct at every DEPTH boundary.
- m_data is combinational from the RX head. It is stable while m_valid=1 and no pop occurs.
- FSM states and transitions:
  - IDLE: go to LOAD when TX not empty AND RX count + 0 < DEPTH, i.e. a free slot is reserved in RX. Otherwise stay.
  - LOAD (1 cycle): ld_master=1, din_master=TX head, TX pop at end of cycle. -> START.
  - START (1 cycle): start=1; counter loaded with XFER_CYCLES-1. -> WAIT.
  - WAIT: counter decrements each cycle. -> READ when counter==0. WAIT lasts exactly XFER_CYCLES cycles.
  - READ (1 cycle): rd_master=1. -> CAPT.
  - CAPT (1 cycle): dout_master sampled and pushed into RX at end of cycle. -> IDLE.
- Strobe values outside their states:
  - din_master holds its last loaded value outside LOAD (it is not cleared).
  - ld_master, start and rd_master are 0 outside their own states.
- Total per byte: 4 + XFER_CYCLES cycles from leaving IDLE to m_valid rising (m_valid rises the cycle after CAPT).
- First-byte latency: byte pushed at edge k -> ld_master high in cycle k+1 (IDLE decides on registered FIFO state).
- Back-to-back transfers: IDLE occupies one cycle between transfers, so the period is 5+XFER_CYCLES cycles.
- RX-full gating:
  - No transfer starts while RX is full; bytes are never dropped.
  - A transfer in flight always has its reserved slot. The IDLE check counts RX occupancy at decision time, and pops during the transfer only free more space.
- Reset mid-transfer: FSM returns to IDLE immediately and all strobes drop asynchronously. The in-flight byte and both FIFO contents are discarded.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro SPI_SEQ_XFER_CNT_EN.
- Defined:
  - Extra output port xfer_count [15:0].
  - Increments by 1 at the end of each CAPT cycle and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, idle:
  - Required: s_ready=1, m_valid=0, busy=0, all strobes 0.
  - No strobe for 50 cycles with s_valid=0.
- Single byte:
  - Stimulus: push 8'hA5; SPI model returns 8'h3C.
  - Required: ld_master with din_master=8'hA5 one cycle after push, then start the next cycle.
  - Required: rd_master exactly XFER_CYCLES cycles after start, then m_valid=1 with m_data=8'h3C at cycle 4+XFER_CYCLES after leaving IDLE.
- Burst:
  - Stimulus: push 8'h01..8'h04 back-to-back.
  - Required: s_ready=1 throughout with DEPTH=4.
  - Required: four transfers, start pulses spaced 5+XFER_CYCLES apart, RX order matches the model's responses.
- RX back-pressure:
  - Stimulus: m_ready=0, push 6 bytes.
  - Required: exactly 4 transfers, then busy=0, 2 bytes still in TX, s_ready=1.
  - Then m_ready=1: remaining 2 transfers complete, 6 bytes delivered in order.
- Reset mid-WAIT:
  - Stimulus: assert rst 3 cycles into WAIT.
  - Required: strobes 0 and busy=0 immediately; after release m_valid=0 and no rd_master pulse.
- With SPI_SEQ_XFER_CNT_EN:
  - xfer_count=3 after 3 transfers.
  - Preload via force to 16'hFFFE, run 3 transfers -> xfer_count=16'hFFFF.
